and_reduce_seq: RTL and testbench
=================================

// Module: and_reduce_seq
// PURPOSE
//  - Sequenced AND-reduction controller for the switch/LED board datapath.
//  - Captures N_IN switch bits on a start request and time-shares one 2-input AND unit serially across them.
//  - Reports result and status on LEDs with a start/done handshake.
//  - Replaces the parallel gate tree; sits between switch inputs and led outputs.
// PARAMETERS
//  - N_IN          4     number of switch bits reduced (>=2)
//  - DEBOUNCE_CYC  16    stable cycles required before a switch change is accepted (SWT_DEBOUNCE_EN only)
// PORTS
//  - clk     in   1     system clock, all logic rising-edge
//  - rst_n   in   1     reset, asynchronous, active-low
//  - swt     in   N_IN  raw slide switches, asynchronous to clk
//  - start   in   1     request a reduction; level sampled each cycle
//  - busy    out  1     high while a reduction is in progress (LOAD/REDUCE)
//  - done    out  1     one-cycle pulse when result becomes valid
//  - result  out  1     AND of captured bits; held until next accepted start
//  - led     out  2     led[0]=result, led[1]=busy
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE; busy=0, done=0, result=0, led=2'b00, count=0, shift reg=0.
//  - Input path: swt -> 2-FF synchroniser -> swt_clean (reset 0).
//  - FSM states:
//    - IDLE:   start=1 -> LOAD; else stay.
//    - LOAD:   shift_reg<=swt_clean, acc<=1, count<=0, busy=1 -> REDUCE.
//    - REDUCE: acc<=and(acc, shift_reg[0]); shift right; count++; at count==N_IN-1 -> DONE.
//    - DONE:   result<=acc, done=1 (exactly this cycle), busy=0.
//      - start=1 -> LOAD (back-to-back run); else -> IDLE.
//  - Start handling:
//    - start accepted only in IDLE/DONE; ignored (not queued) in LOAD/REDUCE.
//    - Held-high start re-triggers every run.
//  - Latency: start high in IDLE at cycle t -> done pulse at cycle t+N_IN+2; fixed, no early exit on a 0 bit.
//  - Switch changes after LOAD do not affect the running reduction.
//  - result/led[0] change only in DONE; stable otherwise.
//  - count width = $clog2(N_IN); never exceeds N_IN-1.
//  - rst_n low mid-run aborts immediately to reset values; no done pulse is produced for the aborted run.
// CONFIGURATION
//  - SWT_DEBOUNCE_EN defined:
//    - Per-bit debouncer after the synchroniser.
//    - swt_clean[i] updates only after the synchronised bit differs from swt_clean[i] for DEBOUNCE_CYC consecutive cycles.
//    - Counter clears on any bounce.
//  - SWT_DEBOUNCE_EN undefined: swt_clean = synchroniser output; DEBOUNCE_CYC unused.
// STRUCTURE
//  - Package and_seq_pkg:
//    - state_t enum {IDLE, LOAD, REDUCE, DONE}, 2-bit encoding.
//    - Localparam LED_RESULT=0, LED_BUSY=1.
//  - Sub-module swt_debounce: one instance per bit under SWT_DEBOUNCE_EN, ports clk, rst_n, din, dout.
//  - FSM, shift register, counter and accumulator stay in the top.
// TESTING
//  - Reset: rst_n=0 with swt=4'hF, start=1 -> led=00, busy=0, done=0, result=0; all held while rst_n=0.
//  - swt=4'b1111, start pulse -> done exactly 6 cycles later, result=1, led=2'b01 after done.
//  - swt=4'b1011, start pulse -> done at +6, result=0; busy high for the 5 cycles before done.
//  - start held high, swt toggled 1111/0111 between runs -> done every 6 cycles; results 1,0 follow the captured values.
//  - start pulse, drop rst_n at REDUCE count=1 -> outputs return to reset values at once; no done pulse; next start runs normally.
//  - SWT_DEBOUNCE_EN, DEBOUNCE_CYC=16: bit bounces every 5 cycles -> swt_clean unchanged; held 16 stable cycles -> swt_clean updates.

Source files
------------

// File: rtl/and_seq_pkg.sv
// Shared types and constants for the sequenced AND-reduction controller.
package and_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    REDUCE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Bit positions inside the led output.
  localparam int LED_RESULT = 0;
  localparam int LED_BUSY   = 1;

endpackage

// File: rtl/and_reduce_seq_swt_debounce.sv
// Single-bit switch debouncer. The output follows the input only after the
// input has disagreed with the output for DEBOUNCE_CYC consecutive cycles.
// Any cycle where they agree again clears the run counter.
module swt_debounce #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             dout_q, dout_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;

  // Count consecutive disagreeing cycles; accept the new level on the last one.
  always_comb begin
    dout_d = dout_q;
    cnt_d  = '0;
    if (din != dout_q) begin
      if (cnt_q == CNT_LAST) begin
        dout_d = din;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      dout_q <= dout_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/and_reduce_seq.sv
// Sequenced AND-reduction controller for the switch/LED board.
// Captures N_IN synchronised switch bits on a start request and ANDs them
// one per cycle through a single 2-input AND, then reports on the LEDs.
// Build option: define SWT_DEBOUNCE_EN to insert a per-bit debouncer
// (DEBOUNCE_CYC stable cycles) between the synchroniser and the capture.
module and_reduce_seq #(
  parameter int N_IN         = 4,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] swt,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            result,
  output logic [1:0]      led
);

  import and_seq_pkg::*;

  localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN - 1);

  // ---------------------------------------------------------------------------
  // Switch input path
  // ---------------------------------------------------------------------------
  logic [N_IN-1:0] sync1_q, sync2_q;
  logic [N_IN-1:0] swt_clean;

  // Two-flop synchroniser; switches are asynchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      // NOTE: non-blocking so both stages sample the pre-edge values; a blocking
      // assignment here would collapse the synchroniser into a single flop.
      sync1_q <= swt;
      sync2_q <= sync1_q;
    end
  end

`ifdef SWT_DEBOUNCE_EN
  for (genvar i = 0; i < N_IN; i++) begin : g_debounce
    swt_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_swt_debounce (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (sync2_q[i]),
      .dout (swt_clean[i])
    );
  end
`else
  assign swt_clean = sync2_q;
`endif

  // ---------------------------------------------------------------------------
  // Controller: FSM, shift register, counter, accumulator, registered outputs
  // ---------------------------------------------------------------------------
  state_t          state_q,  state_d;
  logic [N_IN-1:0] shift_q,  shift_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic            acc_q,    acc_d;
  logic            busy_q,   busy_d;
  logic            done_q,   done_d;
  logic            result_q, result_d;

  // Next-state and datapath logic for one serial reduction.
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves a variable unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          busy_d  = 1'b1;
        end
      end

      LOAD: begin
        shift_d = swt_clean;
        acc_d   = 1'b1;
        cnt_d   = '0;
        state_d = REDUCE;
      end

      REDUCE: begin
        acc_d   = acc_q & shift_q[0];
        shift_d = shift_q >> 1;
        if (cnt_q == CNT_LAST) begin
          // Last bit: publish the final AND together with the done pulse.
          cnt_d    = '0;
          state_d  = DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = acc_q & shift_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        if (start) begin
          state_d = LOAD;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Controller registers; reset aborts any run without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      acc_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign result          = result_q;
  assign led[LED_RESULT] = result_q;
  assign led[LED_BUSY]   = busy_q;

endmodule

// File: tb/tb_and_reduce_seq.sv
// Directed bench for and_reduce_seq with a result scoreboard.
module tb_and_reduce_seq;

  import and_seq_pkg::*;

  localparam int N_IN = 4;
  localparam int LAT  = N_IN + 2;
`ifdef SWT_DEBOUNCE_EN
  localparam int SETTLE = 24;
`else
  localparam int SETTLE = 4;
`endif

  logic            clk    = 1'b0;
  logic            rst_n  = 1'b0;
  logic [N_IN-1:0] swt    = '0;
  logic            start  = 1'b0;
  logic            busy;
  logic            done;
  logic            result;
  logic [1:0]      led;

  int   total = 0;
  int   bad   = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  and_reduce_seq #(
    .N_IN        (N_IN),
    .DEBOUNCE_CYC(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .swt   (swt),
    .start (start),
    .busy  (busy),
    .done  (done),
    .result(result),
    .led   (led)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called n0 cycles after the start edge (n0=1 is the LOAD cycle).
  // Checks busy until done, the done latency, then the scoreboard result.
  task automatic wait_done(input string tag, input logic drop_start, input int n0);
    int   n;
    logic exp;
    n = n0;
    while (done !== 1'b1 && n < 4 * LAT) begin
      check({tag, "_busy"}, {7'd0, busy}, 8'd1);
      tick();
      n++;
    end
    check({tag, "_latency"}, 8'(n), 8'(LAT));
    check({tag, "_busy_at_done"}, {7'd0, busy}, 8'd0);
    if (drop_start) start = 1'b0;
    tick();
    check({tag, "_done_pulse"}, {7'd0, done}, 8'd0);
    check({tag, "_sb_nonempty"}, {7'd0, exp_q.size() != 0}, 8'd1);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
    check({tag, "_result"}, {7'd0, result}, {7'd0, exp});
    check({tag, "_led"}, {6'd0, led}, {6'd0, !drop_start, exp});
  endtask

  task automatic run_one(input string tag, input logic [N_IN-1:0] sw);
    swt = sw;
    repeat (SETTLE) tick();
    exp_q.push_back(&sw);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(tag, 1'b1, 1);
  endtask

  initial begin
    // Reset held with inputs active: everything must stay at reset values.
    rst_n = 1'b0;
    swt   = 4'hF;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_busy",   {7'd0, busy},   8'd0);
      check("rst_done",   {7'd0, done},   8'd0);
      check("rst_result", {7'd0, result}, 8'd0);
      check("rst_led",    {6'd0, led},    8'd0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    tick();

    run_one("all_ones", 4'b1111);
    run_one("one_zero", 4'b1011);
    run_one("msb_zero", 4'b0111);

`ifndef SWT_DEBOUNCE_EN
    // Start held high: back-to-back runs, switches changed after each LOAD.
    begin
      logic [N_IN-1:0] vals [4];
      vals[0] = 4'b1111;
      vals[1] = 4'b0111;
      vals[2] = 4'b1111;
      vals[3] = 4'b0111;
      swt = vals[0];
      repeat (SETTLE) tick();
      exp_q.push_back(&vals[0]);
      start = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
        tick();
        if (i < 3) begin
          swt = vals[i+1];
          exp_q.push_back(&vals[i+1]);
        end else begin
          swt = 4'b0000;
        end
        wait_done("held", i == 3, 2);
      end
    end
`endif

    // Make result=1 so the abort visibly clears it.
    run_one("pre_abort", 4'b1111);

    // Abort in REDUCE with count=1: outputs back to reset at once, no done.
    swt = 4'b1111;
    repeat (SETTLE) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_busy",   {7'd0, busy},   8'd0);
    check("abort_done",   {7'd0, done},   8'd0);
    check("abort_result", {7'd0, result}, 8'd0);
    check("abort_led",    {6'd0, led},    8'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("abort_no_done", {7'd0, done}, 8'd0);
    end

    run_one("post_abort", 4'b1111);
    run_one("lsb_zero", 4'b1110);

`ifdef SWT_DEBOUNCE_EN
    // swt_clean[0] is 0 here; bouncing bit 0 every 5 cycles must not pass.
    for (int i = 0; i < 7; i++) begin
      swt[0] = ~swt[0];
      repeat (5) tick();
      check("db_bounce", {7'd0, dut.swt_clean[0]}, 8'd0);
    end
    repeat (10) tick();
    check("db_not_yet", {7'd0, dut.swt_clean[0]}, 8'd0);
    repeat (12) tick();
    check("db_accept", {7'd0, dut.swt_clean[0]}, 8'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
